core_sequencer: RTL and testbench
=================================

CORE_SEQUENCER -- requirements
Module: core_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the PC value loaded on reset.
REQ-002 SHALL have port clock  input  1  rising-edge clock for all state.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port imem_req  output  1  instruction fetch request.
REQ-005 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  fetch complete; imem_rdata is valid in the same cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port dmem_req  output  1  data access request.
REQ-009 SHALL have port dmem_we  output  1  data access is a store.
REQ-010 SHALL have port dmem_ack  input  1  data access complete.
REQ-011 SHALL have port alu_result  input  32  datapath ALU output, used as the jump/branch target.
REQ-012 SHALL have port br_taken  input  1  datapath branch comparison result.
REQ-013 SHALL have port ir  output  32  latched instruction register.
REQ-014 SHALL have port pc  output  32  program counter.
REQ-015 SHALL have port rf_we  output  1  register-file write enable.
REQ-016 SHALL have port state  output  3  FSM state encoding.
REQ-017 SHALL have port halt  output  1  sequencer halted.
REQ-018 SHALL have port fault  output  1  halt cause was an illegal opcode or a misaligned target.
REQ-019 SHALL have port instret  output  32  retired-instruction count.

Function
REQ-020 SHALL implement states FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to HALT with fault=1.
REQ-021 SHALL, in FETCH, hold imem_req=1 with imem_addr=pc stable until imem_ack; on imem_ack, ir<=imem_rdata and next state is DECODE.
REQ-022 SHALL, in DECODE, take opcode=ir[6:0] for exactly 1 cycle:
- opcodes 0x03, 0x13, 0x17, 0x23, 0x33, 0x37, 0x63, 0x67, 0x6F go to EXECUTE;
- opcode 0x73 goes to HALT with fault=0;
- any other opcode goes to HALT with fault=1.
REQ-023 SHALL, in EXECUTE, spend exactly 1 cycle:
- 0x03 and 0x23 go to MEM;
- 0x63 goes to FETCH with pc<=br_taken ? alu_result : pc+4;
- all others go to WB.
REQ-024 SHALL, in MEM, hold dmem_req=1 with dmem_we=(opcode==0x23) until dmem_ack; a load then goes to WB; a store goes to FETCH with pc<=pc+4.
REQ-025 SHALL, in WB, assert rf_we for exactly 1 cycle iff ir[11:7]!=0, then go to FETCH:
- 0x6F: pc<=alu_result;
- 0x67: pc<=alu_result with bit0 cleared;
- otherwise: pc<=pc+4.
REQ-026 SHALL treat a taken target with bit1 set (after the JALR bit0 clear) as misaligned: pc unchanged, go to HALT, fault=1, no retire.
REQ-027 SHALL wrap pc+4 modulo 2^32 (0xFFFF_FFFC -> 0x0000_0000).
REQ-028 SHALL increment instret by 1 on every transition into FETCH from EXECUTE, MEM or WB, wrapping 0xFFFF_FFFF -> 0.
REQ-029 SHALL ignore imem_ack outside FETCH and dmem_ack outside MEM.
REQ-030 SHALL make HALT sticky until reset: halt=1, and imem_req, dmem_req and rf_we all 0.
REQ-031 SHALL drive imem_req, dmem_req, dmem_we and rf_we as functions of the registered state only, with no combinational path from any input.
REQ-032 SHALL complete a non-memory ALU instruction in 4 cycles (FETCH with same-cycle ack, DECODE, EXECUTE, WB) and a branch in 3 cycles.

Reset
REQ-033 SHALL, while reset=0 and asynchronously, set state=FETCH, pc=RESET_PC, ir=32'h0000_0013, instret=0, halt=0, fault=0, rf_we=0, dmem_req=0, dmem_we=0; imem_req SHALL be 0 during reset.
REQ-034 SHALL abandon any outstanding fetch or data access on reset assertion mid-operation, and SHALL start a fresh fetch at RESET_PC on the first clock edge after reset deassertion.

Verification
REQ-035 SHALL be verified by: ADDI x1 (32'h00100093), imem_ack tied 1 -> states 0,1,2,4; rf_we pulse 1 cycle; pc 0->4; instret 0->1.
REQ-036 SHALL be verified by: fetch with imem_ack delayed 5 cycles -> imem_req high for 6 cycles, imem_addr constant, ir updated only on the ack cycle.
REQ-037 SHALL be verified by: BEQ with br_taken=1, alu_result=0x40 -> pc=0x40 after EXECUTE, no WB, rf_we never asserted; with alu_result=0x42 -> HALT, fault=1.
REQ-038 SHALL be verified by: SW with dmem_ack after 3 cycles -> dmem_req=1 and dmem_we=1 for 4 cycles, then pc+4; LW with rd=x0 -> rf_we stays 0.
REQ-039 SHALL be verified by: ir=32'hFFFFFFFF -> HALT, fault=1, sticky over 100 cycles; ECALL (32'h00000073) -> HALT, fault=0.
REQ-040 SHALL be verified by: reset pulsed low mid-MEM -> dmem_req drops within the same cycle; after release, imem_addr=RESET_PC and instret=0.

Source files
------------

// File: rtl/core_sequencer.sv
// Multi-cycle control sequencer for a single-issue core: walks FETCH/DECODE/
// EXECUTE/MEM/WB, owns pc, ir and the retired-instruction counter.
module core_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  input  logic [31:0] alu_result,
  input  logic        br_taken,
  output logic [31:0] ir,
  output logic [31:0] pc,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halt,
  output logic        fault,
  output logic [31:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;
  localparam logic [31:0] IR_NOP   = 32'h0000_0013;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, instret_q;
  logic        fault_q, fault_d, retire;
  logic        started_q;
  logic [6:0]  opcode;
  logic [31:0] pc_inc, wb_target;
  logic        wb_jump;

  assign opcode = ir_q[6:0];
  assign pc_inc = pc_q + 32'd4;

  always_comb begin
    wb_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
    wb_target = pc_inc;
    if (opcode == OP_JAL)  wb_target = alu_result;
    if (opcode == OP_JALR) wb_target = {alu_result[31:1], 1'b0};
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    fault_d = fault_q;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (started_q && imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
          OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: state_d = S_EXECUTE;
          OP_SYSTEM: state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_EXECUTE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEM;
          OP_BRANCH: begin
            if (br_taken && alu_result[1]) begin
              state_d = S_HALT;
              fault_d = 1'b1;
            end else begin
              pc_d    = br_taken ? alu_result : pc_inc;
              state_d = S_FETCH;
              retire  = 1'b1;
            end
          end
          default: state_d = S_WB;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
            retire  = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        // Jump targets are checked after the JALR bit0 clear.
        if (wb_jump && wb_target[1]) begin
          state_d = S_HALT;
          fault_d = 1'b1;
        end else begin
          pc_d    = wb_target;
          state_d = S_FETCH;
          retire  = 1'b1;
        end
      end
      S_HALT: state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase
  end

  // started_q keeps imem_req low through reset and until the first clean edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= IR_NOP;
      instret_q <= 32'd0;
      fault_q   <= 1'b0;
      started_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_q + {31'd0, retire};
      fault_q   <= fault_d;
      started_q <= 1'b1;
    end
  end

  assign imem_req  = started_q && (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = (state_q == S_MEM) && (opcode == OP_STORE);
  assign rf_we     = (state_q == S_WB) && (ir_q[11:7] != 5'd0);
  assign halt      = (state_q == S_HALT);
  assign fault     = fault_q;
  assign state     = state_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instret   = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Self-checking bench for core_sequencer: instruction vectors from a table
// scored through a queue, plus hand sequences for stall, halt and reset cases.
module tb_core_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack = 1'b0;
  logic [31:0] alu_result;
  logic        br_taken;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        rf_we;
  logic [2:0]  state;
  logic        halt;
  logic        fault;
  logic [31:0] instret;

  core_sequencer dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .alu_result(alu_result), .br_taken(br_taken),
    .ir(ir), .pc(pc), .rf_we(rf_we), .state(state),
    .halt(halt), .fault(fault), .instret(instret)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          rst;
    logic [31:0] instr;
    bit          br;
    logic [31:0] alu;
    int          dlat;
    logic [31:0] pc;
    logic [31:0] ret;
    bit          halt;
    bit          fault;
    int          cyc;
    int          rfwe;
    int          dreq;
    int          dwe;
  } vec_t;

  localparam int NV = 19;
  localparam logic [31:0] ADDI_X1 = 32'h0010_0093;
  localparam logic [31:0] LW_X2   = 32'h0000_A103;

  vec_t vecs [NV];
  vec_t exp_q [$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   imem_lat = 0;
  int   dmem_lat = 0;
  int   i_cnt = 0;
  int   d_cnt = 0;
  bit   ack_all = 1'b0;

  // Memory responders: ack on the (lat+1)-th cycle of a held request.
  always @(negedge clock) begin
    if (imem_req) i_cnt = i_cnt + 1; else i_cnt = 0;
    if (dmem_req) d_cnt = d_cnt + 1; else d_cnt = 0;
    imem_ack = ack_all || (imem_req && (i_cnt == imem_lat + 1));
    dmem_ack = ack_all || (dmem_req && (d_cnt == dmem_lat + 1));
  end

  function automatic vec_t mk(bit rst, logic [31:0] instr, bit br, logic [31:0] alu, int dlat,
                              logic [31:0] epc, logic [31:0] eret, bit eh, bit ef,
                              int ecyc, int erf, int edr, int edw);
    vec_t v;
    v.rst = rst; v.instr = instr; v.br = br; v.alu = alu; v.dlat = dlat;
    v.pc = epc; v.ret = eret; v.halt = eh; v.fault = ef;
    v.cyc = ecyc; v.rfwe = erf; v.dreq = edr; v.dwe = edw;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    int cyc, rfwe, dreq, dwe;
    bit seen, done;
    exp_q.push_back(v);
    if (v.rst) do_reset();
    imem_rdata = v.instr; br_taken = v.br; alu_result = v.alu; dmem_lat = v.dlat;
    cyc = 0; rfwe = 0; dreq = 0; dwe = 0; seen = 0; done = 0;
    for (int k = 0; k < 60; k++) begin
      if (state != 3'd0) seen = 1;
      if (seen && (state == 3'd0 || state == 3'd5)) begin
        done = 1;
        break;
      end
      if (rf_we) rfwe++;
      if (dmem_req) dreq++;
      if (dmem_we) dwe++;
      cyc++;
      @(negedge clock);
    end
    e = exp_q.pop_front();
    chk($sformatf("v%0d done", idx), 32'(done), 32'd1);
    chk($sformatf("v%0d pc", idx), pc, e.pc);
    chk($sformatf("v%0d imem_addr", idx), imem_addr, e.pc);
    chk($sformatf("v%0d instret", idx), instret, e.ret);
    chk($sformatf("v%0d halt", idx), 32'(halt), 32'(e.halt));
    chk($sformatf("v%0d fault", idx), 32'(fault), 32'(e.fault));
    chk($sformatf("v%0d cycles", idx), 32'(cyc), 32'(e.cyc));
    chk($sformatf("v%0d rf_we", idx), 32'(rfwe), 32'(e.rfwe));
    chk($sformatf("v%0d dmem_req", idx), 32'(dreq), 32'(e.dreq));
    chk($sformatf("v%0d dmem_we", idx), 32'(dwe), 32'(e.dwe));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int bad, reqc;
    bit addr_ok, ir_ok;
    logic [14:0] trace;

    //          rst instr         br alu           dl  pc            ret    h  f  cyc rf dr dw
    vecs[0]  = mk(1, ADDI_X1,      0, 32'h0,        0, 32'h4,        32'd1, 0, 0, 4, 1, 0, 0);
    vecs[1]  = mk(0, 32'h0020_81B3, 0, 32'h0,       0, 32'h8,        32'd2, 0, 0, 4, 1, 0, 0);
    vecs[2]  = mk(0, 32'h0000_0013, 0, 32'h0,       0, 32'hC,        32'd3, 0, 0, 4, 0, 0, 0);
    vecs[3]  = mk(0, 32'h0020_8463, 0, 32'h40,      0, 32'h10,       32'd4, 0, 0, 3, 0, 0, 0);
    vecs[4]  = mk(0, 32'h0020_8463, 1, 32'h40,      0, 32'h40,       32'd5, 0, 0, 3, 0, 0, 0);
    vecs[5]  = mk(0, 32'h0020_A023, 0, 32'h0,       3, 32'h44,       32'd6, 0, 0, 7, 0, 4, 4);
    vecs[6]  = mk(0, 32'h0000_A003, 0, 32'h0,       1, 32'h48,       32'd7, 0, 0, 6, 0, 2, 0);
    vecs[7]  = mk(0, LW_X2,        0, 32'h0,        0, 32'h4C,       32'd8, 0, 0, 5, 1, 1, 0);
    vecs[8]  = mk(0, 32'h0080_00EF, 0, 32'h200,     0, 32'h200,      32'd9, 0, 0, 4, 1, 0, 0);
    vecs[9]  = mk(0, 32'h0000_80E7, 0, 32'h301,     0, 32'h300,      32'd10, 0, 0, 4, 1, 0, 0);
    vecs[10] = mk(0, 32'h1234_52B7, 0, 32'h0,       0, 32'h304,      32'd11, 0, 0, 4, 1, 0, 0);
    vecs[11] = mk(0, 32'h0080_00EF, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 32'd12, 0, 0, 4, 1, 0, 0);
    vecs[12] = mk(0, 32'h0000_0297, 0, 32'h0,       0, 32'h0,        32'd13, 0, 0, 4, 1, 0, 0);
    vecs[13] = mk(0, 32'h0020_8463, 1, 32'h42,      0, 32'h0,        32'd13, 1, 1, 3, 0, 0, 0);
    vecs[14] = mk(1, 32'h0000_0073, 0, 32'h0,       0, 32'h0,        32'd0, 1, 0, 2, 0, 0, 0);
    vecs[15] = mk(1, 32'hFFFF_FFFF, 0, 32'h0,       0, 32'h0,        32'd0, 1, 1, 2, 0, 0, 0);
    vecs[16] = mk(1, 32'h0000_000B, 0, 32'h0,       0, 32'h0,        32'd0, 1, 1, 2, 0, 0, 0);
    vecs[17] = mk(1, 32'h0000_8067, 0, 32'h7,       0, 32'h0,        32'd0, 1, 1, 4, 0, 0, 0);
    vecs[18] = mk(1, 32'h0000_8067, 0, 32'h5,       0, 32'h4,        32'd1, 0, 0, 4, 0, 0, 0);

    imem_rdata = 32'h0; alu_result = 32'h0; br_taken = 1'b0;
    reset = 1'b1;
    #1 reset = 1'b0;
    @(negedge clock);
    chk("rst state", 32'(state), 32'd0);
    chk("rst pc", pc, 32'h0);
    chk("rst ir", ir, 32'h0000_0013);
    chk("rst instret", instret, 32'd0);
    chk("rst halt", 32'(halt), 32'd0);
    chk("rst fault", 32'(fault), 32'd0);
    chk("rst rf_we", 32'(rf_we), 32'd0);
    chk("rst dmem_req", 32'(dmem_req), 32'd0);
    chk("rst dmem_we", 32'(dmem_we), 32'd0);
    chk("rst imem_req", 32'(imem_req), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("first fetch imem_req", 32'(imem_req), 32'd1);

    for (int i = 0; i < NV; i++) run_vec(vecs[i], i);

    // Illegal opcode halt must survive 100 cycles of random inputs and acks.
    do_reset();
    imem_rdata = 32'hFFFF_FFFF;
    for (int k = 0; k < 10; k++) begin
      if (halt) break;
      @(negedge clock);
    end
    chk("sticky halt", 32'(halt), 32'd1);
    chk("sticky fault", 32'(fault), 32'd1);
    ack_all = 1'b1;
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      imem_rdata = $urandom; alu_result = $urandom; br_taken = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (!halt || !fault || imem_req || dmem_req || rf_we || state != 3'd5) bad++;
    end
    ack_all = 1'b0;
    chk("sticky violations", 32'(bad), 32'd0);

    // Reset pulsed in the middle of a stalled load.
    do_reset();
    run_vec(mk(0, ADDI_X1, 0, 32'h0, 0, 32'h4, 32'd1, 0, 0, 4, 1, 0, 0), 100);
    imem_rdata = LW_X2; dmem_lat = 20;
    for (int k = 0; k < 10; k++) begin
      if (state == 3'd3) break;
      @(negedge clock);
    end
    @(negedge clock);
    chk("midmem state", 32'(state), 32'd3);
    chk("midmem dmem_req", 32'(dmem_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("async dmem_req", 32'(dmem_req), 32'd0);
    chk("async imem_req", 32'(imem_req), 32'd0);
    chk("async state", 32'(state), 32'd0);
    chk("async pc", pc, 32'h0);
    chk("async instret", instret, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    dmem_lat = 0;
    @(negedge clock);
    chk("post-rst imem_addr", imem_addr, 32'h0);
    chk("post-rst imem_req", 32'(imem_req), 32'd1);
    chk("post-rst instret", instret, 32'd0);

    // ADDI state trace with same-cycle fetch ack.
    do_reset();
    imem_rdata = ADDI_X1;
    trace = '0;
    for (int k = 0; k < 5; k++) begin
      trace = {trace[11:0], state};
      @(negedge clock);
    end
    chk("addi trace", 32'(trace), 32'({3'd0, 3'd1, 3'd2, 3'd4, 3'd0}));
    chk("addi pc", pc, 32'h4);
    chk("addi instret", instret, 32'd1);

    // Fetch stalled five cycles.
    imem_lat = 5;
    do_reset();
    imem_rdata = ADDI_X1;
    reqc = 0; addr_ok = 1; ir_ok = 1;
    for (int k = 0; k < 20; k++) begin
      if (state != 3'd0) break;
      if (imem_req) reqc++;
      if (imem_addr != 32'h0) addr_ok = 0;
      if (ir != 32'h0000_0013) ir_ok = 0;
      @(negedge clock);
    end
    imem_lat = 0;
    chk("stall req cycles", 32'(reqc), 32'd6);
    chk("stall addr stable", 32'(addr_ok), 32'd1);
    chk("stall ir held", 32'(ir_ok), 32'd1);
    chk("stall ir loaded", ir, ADDI_X1);
    chk("stall decode", 32'(state), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
